// File: rtl/sdpb_stream_reader.sv
// sdpb_stream_reader: read side of the 2048x16 simple-dual-port audio loopback.
// Turns the writer pointer into a prefetched valid/ready sample stream.
module sdpb_stream_reader #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 16,
   parameter int START_LEVEL = 256
) (
   input  logic              clkb,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W:0]   wr_ptr,
   output logic              ram_ceb,
   output logic              ram_oce,
   output logic [ADDR_W-1:0] ram_adb,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ADDR_W:0]   level,
   output logic              underrun,
   output logic              overrun,
   output logic [15:0]       underrun_cnt
);

   localparam int PW = ADDR_W + 1;
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] START = PW'(START_LEVEL);

   typedef enum logic [1:0] {
      IDLE,
      PREFILL,
      RUN
   } state_t;

   state_t            state;
   logic [ADDR_W:0]   rd_ptr;
   logic              in_flight;
   logic [DATA_W-1:0] q0;
   logic [DATA_W-1:0] q1;
   logic [1:0]        count;

   logic       pop;
   logic       push;
   logic       ovr_hit;
   logic       und_hit;
   logic       issue;
   logic       flush;
   logic [2:0] occ;

   assign ram_oce = 1'b1;
   assign ram_adb = rd_ptr[ADDR_W-1:0];
   assign level   = wr_ptr - rd_ptr;
   assign m_valid = (count != 2'd0);
   assign m_data  = q0;
   assign pop     = m_valid && m_ready;

   // Words buffered plus the read in flight, after this cycle's pop.
   assign occ = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};

   assign ovr_hit = enable && (state != IDLE) && (level > DEPTH);

   assign und_hit = enable && (state == RUN) && (level == '0)
                 && (count == 2'd0) && !in_flight && m_ready;

   assign issue = enable && (state == RUN) && !ovr_hit
               && (level != '0) && (occ < 3'd2);

   assign ram_ceb = issue;
   assign flush   = !enable || ovr_hit;
   assign push    = in_flight && !flush;

   // Control FSM, read pointer, event pulses and underrun counter.
   always_ff @(posedge clkb or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rd_ptr       <= '0;
         in_flight    <= 1'b0;
         underrun     <= 1'b0;
         overrun      <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         underrun  <= und_hit;
         overrun   <= ovr_hit;
         in_flight <= issue;
         if (und_hit && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
         if (!enable) begin
            state <= IDLE;
         end else if (ovr_hit) begin
            rd_ptr <= wr_ptr;
            state  <= PREFILL;
         end else begin
            if (issue)
               rd_ptr <= rd_ptr + PW'(1);
            unique case (state)
               IDLE: begin
                  rd_ptr <= wr_ptr;
                  state  <= PREFILL;
               end
               PREFILL: begin
                  if (level >= START)
                     state <= RUN;
               end
               RUN: begin
                  if (und_hit)
                     state <= PREFILL;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Two-entry output FIFO; head entry drives the stream.
   always_ff @(posedge clkb or posedge reset) begin
      if (reset) begin
         q0    <= '0;
         q1    <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0)
                  q0 <= ram_dout;
               else
                  q1 <= ram_dout;
               count <= count + 2'd1;
            end
            2'b01: begin
               q0    <= q1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  q0 <= ram_dout;
               end else begin
                  q0 <= q1;
                  q1 <= ram_dout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
